// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM arbiter for an instruction-fetch port and a data port.
// Define MEM_ARBITER_IBUF_EN to add a one-entry fetch buffer that serves repeated fetches without RAM access.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t r_state, w_state_n;
    logic [2:0] r_k;
    logic [1:0] r_last, r_size, w_msz_last;
    logic [ADDR_W-1:0] r_addr, w_addr_k;
    logic r_sign, r_port, r_we, r_if_done, r_mem_done;
    logic [31:0] r_wdata, r_buf, r_if_data, r_mem_rdata, w_raw, w_ext, w_word;
    logic w_last, w_abort, w_fin, w_acc, w_hit;
    assign w_last = r_k == {1'b0, r_last};
    assign w_abort = r_state == READ && !r_port && if_flush;
    assign w_fin = r_state != IDLE && w_last && !w_abort;
    assign w_acc = r_state == IDLE && (mem_req || (if_req && !w_hit));
    assign w_msz_last = mem_size == 2'd0 ? 2'd0 : mem_size == 2'd1 ? 2'd1 : 2'd3;
    // Bytes shift in from the top; the final byte arrives on ram_din during the done cycle itself.
    assign w_raw = {ram_din, r_buf[31:8]} >> {~r_last, 3'b000};
    assign w_ext = r_size == 2'd0 ? {{24{r_sign & w_raw[7]}}, w_raw[7:0]} :
                   r_size == 2'd1 ? {{16{r_sign & w_raw[15]}}, w_raw[15:0]} : w_raw;
    assign w_addr_k = r_addr + ADDR_W'(r_k);
    assign busy = r_state != IDLE;
    assign ram_wr = r_state == WRITE;
    assign ram_a = busy ? w_addr_k[RAM_AW-1:0] : '0;
    assign ram_dout = ram_wr ? r_wdata[{r_k[1:0], 3'b000} +: 8] : 8'h00;
    assign if_done = r_if_done && !if_flush;
    assign if_data = if_done ? w_word : r_if_data;
    assign mem_done = r_mem_done;
    assign mem_rdata = (r_mem_done && !r_we) ? w_ext : r_mem_rdata;
`ifdef MEM_ARBITER_IBUF_EN
    logic r_ib_valid, r_hit;
    logic [ADDR_W-1:0] r_ib_addr;
    logic [31:0] r_ib_word;
    assign w_hit = r_state == IDLE && !mem_req && if_req && r_ib_valid && r_ib_addr == if_addr;
    assign w_word = r_hit ? r_ib_word : w_ext;
    always_ff @(posedge clk) begin
        r_hit <= !rst && w_hit;
        if (rst || (r_state == IDLE && mem_req && mem_we)) begin
            r_ib_valid <= 1'b0;
        end else if (if_done && !r_hit) begin
            r_ib_valid <= 1'b1;
            r_ib_addr <= r_addr;
            r_ib_word <= w_ext;
        end
    end
`else
    assign w_hit = 1'b0;
    assign w_word = w_ext;
`endif
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_state_n;
    end
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    w_state_n = mem_req ? (mem_we ? WRITE : READ) : (if_req && !w_hit) ? READ : IDLE;
            default: w_state_n = (w_abort || w_last) ? IDLE : r_state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k <= 3'd0;
            r_if_done <= 1'b0;
            r_mem_done <= 1'b0;
            r_if_data <= 32'h0;
            r_mem_rdata <= 32'h0;
        end else begin
            r_k <= (busy && !w_last && !w_abort) ? r_k + 3'd1 : 3'd0;
            r_if_done <= (w_fin && !r_port) || w_hit;
            r_mem_done <= w_fin && r_port;
            if (if_done) r_if_data <= w_word;
            if (r_mem_done && !r_we) r_mem_rdata <= w_ext;
        end
    end
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_addr <= mem_req ? mem_addr : if_addr;
            r_port <= mem_req;
            r_we <= mem_req && mem_we;
            r_last <= mem_req ? w_msz_last : 2'd3;
            r_size <= mem_req ? mem_size : 2'd2;
            r_sign <= mem_req && mem_sign;
            r_wdata <= mem_wdata;
        end
        if (r_state == READ && r_k != 3'd0) r_buf <= {ram_din, r_buf[31:8]};
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a byte RAM model with one-cycle read latency.
module tb_mem_arbiter;
    logic clk = 1'b0, rst;
    logic if_req, if_flush, if_done, mem_req, mem_we, mem_sign, mem_done, ram_wr, busy;
    logic [31:0] if_addr, mem_addr, if_data, mem_wdata, mem_rdata;
    logic [1:0] mem_size;
    logic [7:0] ram_din, ram_dout;
    logic [16:0] ram_a;
    logic [7:0] ram [0:131071];
    int total = 0, bad = 0;
`ifdef MEM_ARBITER_IBUF_EN
    localparam int HIT_LAT = 1;
    localparam logic [31:0] F2_DATA = 32'h13;
`else
    localparam int HIT_LAT = 5;
    localparam logic [31:0] F2_DATA = 32'h77;
`endif

    mem_arbiter #(.ADDR_W(32), .RAM_AW(17)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_sign(mem_sign), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input int lat, input string tag);
        int c = 0;
        if_req = 1'b1;
        if_addr = a;
        do begin
            @(negedge clk);
            c++;
        end while (!if_done && c < 12);
        chk({tag, ".lat"}, c, lat);
        chk({tag, ".data"}, if_data, exp);
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_mem(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp, input int lat, input string tag);
        int c = 0;
        mem_req = 1'b1;
        mem_we = we;
        mem_size = sz;
        mem_sign = sg;
        mem_addr = a;
        mem_wdata = wd;
        do begin
            @(negedge clk);
            c++;
        end while (!mem_done && c < 12);
        chk({tag, ".lat"}, c, lat);
        if (!we) chk({tag, ".data"}, mem_rdata, exp);
        mem_req = 1'b0;
        mem_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;
        rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_size = '0; mem_sign = 1'b0; mem_wdata = '0;
        for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
        ram[32'h100] = 8'h13;
        ram[32'h20] = 8'h80;
        ram[32'h40] = 8'h34; ram[32'h41] = 8'h92;
        ram[32'h44] = 8'h11; ram[32'h45] = 8'h22; ram[32'h46] = 8'h33; ram[32'h47] = 8'h44;
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.ram_a", ram_a, 0);
        chk("rst.ram_wr", ram_wr, 0);
        chk("rst.ram_dout", ram_dout, 0);
        chk("rst.if_done", if_done, 0);
        chk("rst.mem_done", mem_done, 0);
        chk("rst.if_data", if_data, 0);
        chk("rst.mem_rdata", mem_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        if_req = 1'b1;
        if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("if.ram_a", ram_a, 32'h100 + k);
            chk("if.busy", busy, 1);
            chk("if.ram_wr", ram_wr, 0);
            chk("if.early_done", if_done, 0);
        end
        @(negedge clk);
        chk("if.done", if_done, 1);
        chk("if.data", if_data, 32'h13);
        chk("if.idle", busy, 0);
        if_req = 1'b0;
        @(negedge clk);
        chk("if.done_pulse", if_done, 0);
        chk("if.data_hold", if_data, 32'h13);

        do_mem(1'b0, 2'd0, 1'b1, 32'h20, 0, 32'hFFFFFF80, 2, "lbs");
        chk("lb.hold", mem_rdata, 32'hFFFFFF80);
        do_mem(1'b0, 2'd0, 1'b0, 32'h20, 0, 32'h00000080, 2, "lbu");
        do_mem(1'b0, 2'd1, 1'b1, 32'h40, 0, 32'hFFFF9234, 3, "lhs");
        do_mem(1'b0, 2'd1, 1'b0, 32'h40, 0, 32'h00009234, 3, "lhu");
        do_mem(1'b0, 2'd2, 1'b0, 32'h44, 0, 32'h44332211, 5, "lw");
        do_mem(1'b0, 2'd3, 1'b1, 32'h44, 0, 32'h44332211, 5, "lsz3");

        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1; mem_addr = 32'h1FFFF; mem_wdata = 32'h1234BEEF;
        @(negedge clk);
        chk("sh.wr0", ram_wr, 1); chk("sh.a0", ram_a, 32'h1FFFF); chk("sh.d0", ram_dout, 32'hEF);
        @(negedge clk);
        chk("sh.wr1", ram_wr, 1); chk("sh.a1", ram_a, 0); chk("sh.d1", ram_dout, 32'hBE);
        @(negedge clk);
        chk("sh.done", mem_done, 1); chk("sh.wr_end", ram_wr, 0); chk("sh.a_idle", ram_a, 0);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("sh.ram_lo", ram[17'h1FFFF], 32'hEF);
        chk("sh.ram_hi", ram[0], 32'hBE);
        do_mem(1'b0, 2'd1, 1'b0, 32'h1FFFF, 0, 32'h0000BEEF, 3, "lh_wrap");

        if_req = 1'b1; if_addr = 32'h44;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_sign = 1'b0; mem_addr = 32'h20;
        @(negedge clk);
        chk("pri.ram_a", ram_a, 32'h20);
        @(negedge clk);
        chk("pri.mem_done", mem_done, 1);
        chk("pri.if_wait", if_done, 0);
        chk("pri.rdata", mem_rdata, 32'h80);
        mem_req = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!if_done && c < 12);
        chk("pri.if_lat", c, 5);
        chk("pri.if_data", if_data, 32'h44332211);
        if_req = 1'b0;
        @(negedge clk);

        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) @(negedge clk);
        if_flush = 1'b1;
        @(negedge clk);
        chk("fl.idle", busy, 0);
        chk("fl.no_done", if_done, 0);
        chk("fl.ram_a", ram_a, 0);
        if_req = 1'b0; if_flush = 1'b0;
        @(negedge clk);
        chk("fl.no_done2", if_done, 0);
        chk("fl.data_keep", if_data, 32'h44332211);

        if_req = 1'b1; if_addr = 32'h100;
        repeat (5) @(negedge clk);
        if_flush = 1'b1;
        #1;
        chk("fld.suppress", if_done, 0);
        chk("fld.data_keep", if_data, 32'h44332211);
        if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        #1;
        chk("fld.no_done", if_done, 0);
        chk("fld.data_keep2", if_data, 32'h44332211);

        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h200; mem_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("rs.wr", ram_wr, 1);
        chk("rs.dout", ram_dout, 32'hA5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rs.wr_off", ram_wr, 0);
        chk("rs.busy", busy, 0);
        chk("rs.no_done", mem_done, 0);
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("rs.no_done2", mem_done, 0);
        chk("rs.wr_off2", ram_wr, 0);
        chk("rs.ram2", ram[17'h202], 0);
        chk("rs.ram3", ram[17'h203], 0);
        chk("rs.rdata", mem_rdata, 0);
        chk("rs.if_data", if_data, 0);

        do_fetch(32'h100, 32'h13, 5, "f1");
        ram[17'h100] = 8'h77;
        do_fetch(32'h100, F2_DATA, HIT_LAT, "f2");
`ifdef MEM_ARBITER_IBUF_EN
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("hit.done", if_done, 1);
        chk("hit.busy", busy, 0);
        chk("hit.ram_a", ram_a, 0);
        chk("hit.data", if_data, 32'h13);
        if_req = 1'b0;
        @(negedge clk);
`endif
        do_mem(1'b1, 2'd0, 1'b0, 32'h300, 32'h5A, 0, 2, "sb");
        chk("sb.ram", ram[17'h300], 32'h5A);
        do_fetch(32'h100, 32'h77, 5, "f3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
